keccak_readout_seq: RTL
=======================

Name: keccak_readout_seq

Overview:
- Sequences readout of a 512-bit Keccak digest as a stream of 32-bit words.
- Captures the digest from keccak_ctrl when the core finishes.
- Drives the word-select number and enable of the 512-to-32 word divider, and returns its 32-bit word back into the block.
- Presents the words on a valid/ready stream to the processor custom-instruction path.
- Owns all sequencing of the divider: no other block drives its select.

Parameters:
- NUM_WORDS, 16, words per digest; must equal DIG_W/WORD_W.
- WORD_W, 32, width of one output word.
- DIG_W, 512, digest width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- dig_valid  in  1  digest_in holds a finished digest.
- dig_in  in  512  digest from keccak_ctrl.
- dig_ack  out  1  one-cycle pulse: digest captured.
- start  in  1  begin streaming; honoured only in LOADED.
- rd_len  in  5  words to emit, latched at start; 0 means 16; values >16 are clamped to 16.
- abort  in  1  synchronous abort to IDLE.
- div_in512  out  512  captured digest buffer, drives the divider's 512-bit input.
- div_num  out  6  word index to the divider; bits [5:4] are always 0.
- div_en  out  1  divider enable.
- div_word  in  32  selected word returned from the divider (combinational in div_num).
- out_data  out  32  stream data.
- out_valid  out  1  stream data valid.
- out_ready  in  1  consumer ready.
- busy  out  1  high in LOADED or STREAM.
- done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
Reset (async):
- State = IDLE.
- Buffer, out_data and div_num = 0.
- out_valid, dig_ack, done, div_en and busy = 0.

States: IDLE, LOADED, STREAM.

IDLE:
- dig_valid=1 → buffer <= dig_in; dig_ack=1 for the next cycle; go to LOADED.
- start is ignored.

LOADED:
- busy=1; the buffer is held.
- start=1 → latch len = (rd_len==0 || rd_len>16) ? 16 : rd_len; word counter cnt=0; div_num=0; go to STREAM.
- dig_valid is ignored, and dig_ack stays 0, in LOADED and STREAM.

STREAM:
- div_en=1.
- Load condition: load when (!out_valid || out_ready) and loaded-words < len. On load: out_data <= div_word, out_valid <= 1, div_num increments.
- Hold condition: out_valid=1 && out_ready=0 → out_data and out_valid are held stable.
- A word is accepted on any cycle with out_valid && out_ready.
- Last word: when the len-th word is accepted, out_valid <= 0, done pulses 1 cycle, and the state goes to IDLE.

Stream latency:
- start accepted at edge T → STREAM from T.
- First out_valid=1 after edge T+1.
- With out_ready held at 1, one word per cycle: 16 words occupy cycles T+1..T+16, and done is high in cycle T+17.

Word order and divider output:
- Words are emitted in order: word k = dig_in[32k+31:32k].
- div_num is never ≥ NUM_WORDS. After the final load it may equal the last index; it returns to 0 in IDLE.
- div_en is 0 outside STREAM.

abort:
- Highest priority in every state: next cycle is IDLE, out_valid=0, with no done pulse.
- The buffer is kept and no dig_ack is issued.

Reset mid-stream: immediate return to reset values.

Simultaneous events:
- dig_valid and start in the same IDLE cycle → capture only; start is ignored.
- abort with out_valid && out_ready → the transfer counts at the consumer, then the state goes to IDLE.

Test Plan:
- Reset, then dig_in = {16 words 0x0F0F0000+k}, dig_valid=1, start=1 with rd_len=0, out_ready=1 → dig_ack pulse; words 0x0F0F0000..0x0F0F000F on 16 consecutive cycles; done one cycle after the last; busy=0 afterwards.
- rd_len=3 → exactly words 0,1,2 emitted; done after word 2; div_num never exceeds 2.
- out_ready toggling 1,0,0,1,... during a 16-word read → out_data stable while stalled; no word lost or duplicated; 16 transfers total.
- dig_valid pulses during STREAM with a different digest → no dig_ack; streamed words still come from the first digest.
- abort asserted after the 5th transfer → out_valid=0 next cycle, no done, state IDLE; a new start is ignored until a new dig_valid.
- rst asserted asynchronously mid-stream (between clock edges) → out_valid, busy and div_en fall immediately; out_data=0.

Source files
------------

// File: rtl/keccak_readout_seq.sv
// Streams a captured 512-bit Keccak digest as 32-bit words over valid/ready,
// sequencing the external 512-to-32 word divider through div_num/div_en.
module keccak_readout_seq #(
    parameter int NUM_WORDS = 16,
    parameter int WORD_W    = 32,
    parameter int DIG_W     = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dig_valid,
    input  logic [DIG_W-1:0]  dig_in,
    output logic              dig_ack,
    input  logic              start,
    input  logic [4:0]        rd_len,
    input  logic              abort,
    output logic [DIG_W-1:0]  div_in512,
    output logic [5:0]        div_num,
    output logic              div_en,
    input  logic [WORD_W-1:0] div_word,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOADED = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    localparam logic [4:0] MAX_LEN = 5'(NUM_WORDS);

    state_t              state_q, state_d;
    logic [DIG_W-1:0]    buf_q, buf_d;
    logic [WORD_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic [3:0]          idx_q, idx_d;
    logic [4:0]          len_q, len_d;
    logic [4:0]          ld_cnt_q, ld_cnt_d;
    logic [4:0]          acc_cnt_q, acc_cnt_d;
    logic                dig_ack_q, dig_ack_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                div_en_q, div_en_d;
    logic                accept_s;

    assign accept_s = out_valid_q && out_ready;

    // Next-state and datapath decisions; abort outranks everything else.
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        idx_d       = idx_q;
        len_d       = len_q;
        ld_cnt_d    = ld_cnt_q;
        acc_cnt_d   = acc_cnt_q;
        dig_ack_d   = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                idx_d = 4'd0;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (dig_valid) begin
                    buf_d     = dig_in;
                    dig_ack_d = 1'b1;
                    state_d   = S_LOADED;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOADED: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    len_d     = (rd_len == 5'd0 || rd_len > MAX_LEN) ? MAX_LEN : rd_len;
                    ld_cnt_d  = 5'd0;
                    acc_cnt_d = 5'd0;
                    idx_d     = 4'd0;
                    state_d   = S_STREAM;
                end else begin
                    state_d = S_LOADED;
                end
            end
            S_STREAM: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    idx_d       = 4'd0;
                    state_d     = S_IDLE;
                end else if (accept_s && (acc_cnt_q == len_q - 5'd1)) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    idx_d       = 4'd0;
                    state_d     = S_IDLE;
                end else begin
                    if (accept_s) begin
                        acc_cnt_d = acc_cnt_q + 5'd1;
                    end else begin
                        acc_cnt_d = acc_cnt_q;
                    end
                    if ((!out_valid_q || out_ready) && (ld_cnt_q < len_q)) begin
                        out_data_d  = div_word;
                        out_valid_d = 1'b1;
                        ld_cnt_d    = ld_cnt_q + 5'd1;
                        // Stop advancing on the final load so the index never passes len-1.
                        if ((ld_cnt_q + 5'd1) < len_q) begin
                            idx_d = idx_q + 4'd1;
                        end else begin
                            idx_d = idx_q;
                        end
                    end else if (accept_s) begin
                        out_valid_d = 1'b0;
                    end else begin
                        out_valid_d = out_valid_q;
                    end
                end
            end
            default: begin
                out_valid_d = 1'b0;
                idx_d       = 4'd0;
                state_d     = S_IDLE;
            end
        endcase
        busy_d   = (state_d != S_IDLE);
        div_en_d = (state_d == S_STREAM);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            buf_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            idx_q       <= 4'd0;
            len_q       <= 5'd0;
            ld_cnt_q    <= 5'd0;
            acc_cnt_q   <= 5'd0;
            dig_ack_q   <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            div_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            ld_cnt_q    <= ld_cnt_d;
            acc_cnt_q   <= acc_cnt_d;
            dig_ack_q   <= dig_ack_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            div_en_q    <= div_en_d;
        end
    end

    assign div_in512 = buf_q;
    assign div_num   = {2'b00, idx_q};
    assign div_en    = div_en_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign dig_ack   = dig_ack_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule
